// File: rtl/bus_rd_arb_if.sv
// Read-path bundle between two requesting masters, the arbiter and memory.
// Modports: slave = arbiter view, master = environment (masters + memory).
interface bus_rd_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [1:0]              m_arvalid;
  logic [1:0]              m_arready;
  logic [2*ADDR_WIDTH-1:0] m_araddr;
  logic [1:0]              m_rvalid;
  logic [1:0]              m_rready;
  logic [DATA_WIDTH-1:0]   m_rdata;
  logic [1:0]              m_rresp;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_rvalid;
  logic                    s_rready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;

  modport slave (
    input  m_arvalid, m_araddr, m_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp,
    output m_arready, m_rvalid, m_rdata, m_rresp,
    output s_arvalid, s_araddr, s_rready
  );

  modport master (
    output m_arvalid, m_araddr, m_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp,
    input  m_arready, m_rvalid, m_rdata, m_rresp,
    input  s_arvalid, s_araddr, s_rready
  );
endinterface

// File: rtl/bus_rd_arb.sv
// Two-master (IFU=0, LSU=1) read arbiter, one outstanding transaction.
// Ports: clk, rst_n (sync, active-low), bus (bus_rd_arb_if.slave), busy.
// Macro BUS_RD_ARB_FIXED_PRIO_EN: LSU always wins ties (else round-robin).
module bus_rd_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_rd_arb_if.slave       bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  s_arvalid_q, s_arvalid_d;
  logic                  s_rready_q, s_rready_d;
  logic [1:0]            m_rvalid_q, m_rvalid_d;
  logic [1:0]            grant;
  logic                  win;

  always_comb begin
`ifdef BUS_RD_ARB_FIXED_PRIO_EN
    win = bus.m_arvalid[1];
`else
    // On a tie, favour whoever was not served last.
    if (&bus.m_arvalid) win = ~last_q;
    else                win = bus.m_arvalid[1];
`endif
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    s_arvalid_d = s_arvalid_q;
    s_rready_d  = s_rready_q;
    m_rvalid_d  = m_rvalid_q;
    grant       = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_arvalid) begin
          grant       = win ? 2'b10 : 2'b01;
          owner_d     = win;
          addr_d      = win ? bus.m_araddr[ADDR_WIDTH +: ADDR_WIDTH]
                            : bus.m_araddr[0 +: ADDR_WIDTH];
          s_arvalid_d = 1'b1;
          state_d     = AR;
        end
      end
      AR: begin
        if (bus.s_arready) begin
          s_arvalid_d = 1'b0;
          s_rready_d  = 1'b1;
          state_d     = R;
        end
      end
      R: begin
        if (bus.s_rvalid) begin
          rdata_d    = bus.s_rdata;
          rresp_d    = bus.s_rresp;
          s_rready_d = 1'b0;
          m_rvalid_d = owner_q ? 2'b10 : 2'b01;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.m_rready[owner_q]) begin
          m_rvalid_d = 2'b00;
          last_d     = owner_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      s_arvalid_q <= 1'b0;
      s_rready_q  <= 1'b0;
      m_rvalid_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      s_arvalid_q <= s_arvalid_d;
      s_rready_q  <= s_rready_d;
      m_rvalid_q  <= m_rvalid_d;
    end
  end

  // Grant is the only combinational output; hold it off during reset.
  assign bus.m_arready = grant & {2{rst_n}};
  assign bus.m_rvalid  = m_rvalid_q;
  assign bus.m_rdata   = rdata_q;
  assign bus.m_rresp   = rresp_q;
  assign bus.s_arvalid = s_arvalid_q;
  assign bus.s_araddr  = addr_q;
  assign bus.s_rready  = s_rready_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/bus_rd_arb.md
BUS_RD_ARB -- requirements
Module: bus_rd_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width, equal to XLEN.
REQ-002 Parameter DATA_WIDTH, default 64: read data width, one cache block per beat.
REQ-003 clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 m_arvalid  input  2  read request valid; bit 0 is IFU, bit 1 is LSU.
REQ-006 m_arready  output  2  read request accepted, one bit per master.
REQ-007 m_araddr  input  2*ADDR_WIDTH  request addresses; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 m_rvalid  output  2  read response valid, one bit per master.
REQ-009 m_rready  input  2  response accepted, one bit per master.
REQ-010 m_rdata  output  DATA_WIDTH  response data, shared by both masters.
REQ-011 m_rresp  output  2  response code, shared by both masters.
REQ-012 s_arvalid / s_arready  output / input  1 / 1  downstream AR handshake.
REQ-013 s_araddr  output  ADDR_WIDTH  downstream AR address.
REQ-014 s_rvalid / s_rready  input / output  1 / 1  downstream R handshake.
REQ-015 s_rdata / s_rresp  input  DATA_WIDTH / 2  downstream R payload.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL implement the FSM IDLE -> AR -> R -> RESP -> IDLE and allow exactly one outstanding transaction.
REQ-018 IDLE: when any m_arvalid bit is set, the block SHALL pick a winner w, drive m_arready[w]=1 combinationally for that cycle, and register m_araddr slice w into addr_q and w into owner_q. It SHALL then set s_arvalid=1 and move to AR.
REQ-019 m_arready SHALL be 0 in every state other than IDLE, and 0 for the non-winner.
REQ-020 AR: s_araddr=addr_q and s_arvalid is held at 1. On s_arready=1 the block SHALL register s_arvalid=0 and s_rready=1 and move to R.
REQ-021 R: on s_rvalid=1 the block SHALL capture s_rdata and s_rresp into registers, set s_rready=0, set m_rvalid[owner_q]=1, and move to RESP.
REQ-022 RESP: m_rvalid[owner_q] and m_rdata/m_rresp SHALL stay stable until m_rready[owner_q]=1. That cycle the block SHALL clear m_rvalid, set last_q=owner_q, and return to IDLE.
REQ-023 A new request SHALL NOT be accepted in the cycle RESP completes; the earliest next m_arready is the following cycle.
REQ-024 Minimum latency, with zero-wait downstream: request at cycle 0, s_arvalid at cycle 1, s_rready at cycle 2, m_rvalid at cycle 3.
REQ-025 Round-robin: if both masters request, the winner SHALL be the master other than last_q; a single requester SHALL always win.
REQ-026 s_rresp SHALL be forwarded unmodified; an error response (SLVERR/DECERR) SHALL NOT alter the sequencing.
REQ-027 m_rvalid SHALL be one-hot or zero; the bit of the non-owner is always 0.
REQ-028 All s_* and m_r* outputs SHALL be driven from registers; only m_arready is combinational.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE, owner_q=0, last_q=1 (IFU wins the first tie), addr_q=0, captured data/resp=0.
REQ-030 Outputs under reset: s_arvalid=0, s_rready=0, m_rvalid=0, m_arready=0, busy=0.
REQ-031 Reset mid-transaction SHALL discard the transaction with no response to the master; the bench keeps the downstream quiescent across reset.

Configuration
REQ-032 With macro BUS_RD_ARB_FIXED_PRIO_EN defined, master 1 (LSU) SHALL always win when both request, and last_q is unused.
REQ-033 Without BUS_RD_ARB_FIXED_PRIO_EN, the round-robin rule of REQ-025 SHALL apply.

Verification
REQ-034 Single IFU read of 0x8000_0000, zero-wait downstream, s_rdata=0x1122334455667788 -> s_araddr=0x8000_0000 at cycle 1; m_rvalid=2'b01 with that data at cycle 3.
REQ-035 Both masters request continuously, 4 transactions (no BUS_RD_ARB_FIXED_PRIO_EN) -> grant order IFU, LSU, IFU, LSU. With the macro defined -> LSU on all 4.
REQ-036 s_arready held low 5 cycles -> s_arvalid and s_araddr stable throughout; m_arready stays 0 for a new request arriving meanwhile.
REQ-037 m_rready[1] low 3 cycles in RESP with s_rresp=2'b10 -> m_rvalid=2'b10, m_rresp=2'b10 and data stable; IDLE is re-entered the cycle after m_rready.
REQ-038 rst_n=0 for one cycle while in R -> next cycle state IDLE, all valids 0, busy 0. The next request is serviced normally, with IFU winning the first tie.
